// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - sequencer state encodings, parameter limits and width helper for clk_en_gen
package clk_pkg;

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] DELAY     = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 8;
  localparam int DW_MIN  = 2;
  localparam int DW_MAX  = 24;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - one clock-enable channel: shadow divisor, pending flag, down-counter, toggle
// Optional feature: CLK_TOG_EN adds the divide-by-2 toggle flop; otherwise tog is tied to 0.
module clk_en_div #(
  parameter int DW      = 16,
  parameter int DIV_RST = 2
) (
  input  logic          mclk,
  input  logic          RESET,
  input  logic          run,
  input  logic          ld,
  input  logic [DW-1:0] val,
  input  logic          sync,
  output logic          ce,
  output logic          tog,
  output logic          pend_nxt
);

  localparam logic [DW-1:0] DIV_INIT = DW'(DIV_RST);
  localparam logic [DW-1:0] ONE      = DW'(1);

  logic [DW-1:0] shd_q, shd_d;
  logic [DW-1:0] act_q, act_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ce_q, ce_d;

  always_comb begin
    shd_d  = shd_q;
    pend_d = pend_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    ce_d   = 1'b0;
    if (ld) begin
      shd_d  = (val == '0) ? ONE : val;
      pend_d = 1'b1;
    end
    // A same-cycle write is visible to the sync or terminal count below.
    if (!run) begin
      cnt_d = act_q - ONE;
    end else if (sync) begin
      act_d  = shd_d;
      pend_d = 1'b0;
      cnt_d  = shd_d - ONE;
    end else if (cnt_q == '0) begin
      ce_d = 1'b1;
      if (pend_d) begin
        act_d  = shd_d;
        pend_d = 1'b0;
      end
      cnt_d = act_d - ONE;
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge mclk or posedge RESET) begin
    if (RESET) begin
      shd_q  <= DIV_INIT;
      act_q  <= DIV_INIT;
      cnt_q  <= DIV_INIT - ONE;
      pend_q <= 1'b0;
      ce_q   <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ce_q   <= ce_d;
    end
  end

  assign ce       = ce_q;
  assign pend_nxt = pend_d;

`ifdef CLK_TOG_EN
  logic tog_q, tog_d;

  always_comb begin
    tog_d = run ? (tog_q ^ ce_d) : 1'b0;
  end

  always_ff @(posedge mclk or posedge RESET) begin
    if (RESET) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign tog = tog_q;
`else
  assign tog = 1'b0;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - lock/delay reset sequencer plus NCH programmable clock-enable channels
// Optional feature: CLK_TOG_EN enables the per-channel clk_tog square waves.
module clk_en_gen
  import clk_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int RST_DLY = 16,
  parameter int DIV_RST = 2
) (
  input  logic                     mclk,
  input  logic                     RESET,
  input  logic                     pll_lock,
  input  logic                     div_ld,
  input  logic [ch_width(NCH)-1:0] div_ch,
  input  logic [DW-1:0]            div_val,
  input  logic                     sync_req,
  output logic                     rstb,
  output logic [NCH-1:0]           ce_out,
  output logic [NCH-1:0]           clk_tog,
  output logic                     busy
);

  localparam int CHW = ch_width(NCH);
  localparam logic [7:0] DLY_LAST = 8'(RST_DLY - 1);

  logic [1:0]     state_q, state_d;
  logic [7:0]     dly_q, dly_d;
  logic           rstb_q, rstb_d;
  logic           busy_q, busy_d;
  logic [NCH-1:0] pend_nxt;
  logic           run_stay;
  logic           ld_ok;
  logic           sync_ok;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      WAIT_LOCK: begin
        if (pll_lock) begin
          state_d = DELAY;
          dly_d   = '0;
        end
      end
      DELAY: begin
        if (!pll_lock) begin
          state_d = WAIT_LOCK;
        end else if (dly_q == DLY_LAST) begin
          state_d = RUN;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      RUN: begin
        if (!pll_lock) begin
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Channels only count on cycles that stay in RUN, so a lock loss freezes them on the same edge.
  assign run_stay = (state_q == RUN) && pll_lock;
  assign ld_ok    = div_ld && ((state_q == DELAY) || (state_q == RUN));
  assign sync_ok  = sync_req && run_stay;

  assign rstb_d = (state_d == RUN);
  assign busy_d = |pend_nxt;

  always_ff @(posedge mclk or posedge RESET) begin
    if (RESET) begin
      state_q <= WAIT_LOCK;
      dly_q   <= '0;
      rstb_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rstb_q  <= rstb_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_en_div #(
      .DW      (DW),
      .DIV_RST (DIV_RST)
    ) u_div (
      .mclk     (mclk),
      .RESET    (RESET),
      .run      (run_stay),
      .ld       (ld_ok && (div_ch == CHW'(i))),
      .val      (div_val),
      .sync     (sync_ok),
      .ce       (ce_out[i]),
      .tog      (clk_tog[i]),
      .pend_nxt (pend_nxt[i])
    );
  end

  assign rstb = rstb_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - scoreboard bench for clk_en_gen with a time-based channel reference model
module tb_clk_en_gen;

  localparam int NCH     = 4;
  localparam int DW      = 16;
  localparam int RST_DLY = 16;
  localparam int DIV_RST = 2;

  logic           mclk = 1'b0;
  logic           RESET = 1'b1;
  logic           pll_lock = 1'b0;
  logic           div_ld = 1'b0;
  logic [1:0]     div_ch = '0;
  logic [DW-1:0]  div_val = '0;
  logic           sync_req = 1'b0;
  logic           rstb;
  logic [NCH-1:0] ce_out;
  logic [NCH-1:0] clk_tog;
  logic           busy;

  clk_en_gen #(
    .NCH     (NCH),
    .DW      (DW),
    .RST_DLY (RST_DLY),
    .DIV_RST (DIV_RST)
  ) dut (
    .mclk     (mclk),
    .RESET    (RESET),
    .pll_lock (pll_lock),
    .div_ld   (div_ld),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .sync_req (sync_req),
    .rstb     (rstb),
    .ce_out   (ce_out),
    .clk_tog  (clk_tog),
    .busy     (busy)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic           rstb;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] tog;
    logic           busy;
  } vec_t;

  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: lock history as a run length, channels as absolute next-pulse times.
  int cyc = 0;
  int lockc = 0;
  int act[NCH];
  int shd[NCH];
  int nxt[NCH];
  bit pend[NCH];
  bit tog_m[NCH];

  function automatic void model_reset();
    lockc = 0;
    for (int i = 0; i < NCH; i++) begin
      act[i] = DIV_RST;
      shd[i] = DIV_RST;
      nxt[i] = 0;
      pend[i] = 1'b0;
      tog_m[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    vec_t e;
    int   prev;
    bit   staying, entering, ld_ok, pulse;
    cyc++;
    e = '0;
    if (RESET) begin
      model_reset();
      exp_q.push_back(e);
      return;
    end
    prev = lockc;
    lockc = pll_lock ? ((lockc < 100000) ? lockc + 1 : lockc) : 0;
    staying = (prev >= RST_DLY + 1) && pll_lock;
    entering = (lockc == RST_DLY + 1);
    ld_ok = div_ld && (prev >= 1);
    for (int i = 0; i < NCH; i++) begin
      pulse = 1'b0;
      if (ld_ok && (int'(div_ch) == i)) begin
        shd[i] = (div_val == '0) ? 1 : int'(div_val);
        pend[i] = 1'b1;
      end
      if (staying) begin
        if (sync_req) begin
          act[i] = shd[i];
          pend[i] = 1'b0;
          nxt[i] = cyc + act[i];
        end else if (cyc == nxt[i]) begin
          pulse = 1'b1;
          if (pend[i]) begin
            act[i] = shd[i];
            pend[i] = 1'b0;
          end
          nxt[i] = cyc + act[i];
        end
      end else if (entering) begin
        nxt[i] = cyc + act[i];
      end
      tog_m[i] = staying ? (tog_m[i] ^ pulse) : 1'b0;
      e.ce[i] = pulse;
`ifdef CLK_TOG_EN
      e.tog[i] = tog_m[i];
`else
      e.tog[i] = 1'b0;
`endif
      e.busy = e.busy | pend[i];
    end
    e.rstb = (lockc >= RST_DLY + 1);
    exp_q.push_back(e);
  endfunction

  task automatic check_vec(input string name, input vec_t got, input vec_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got rstb=%b ce=%b tog=%b busy=%b want rstb=%b ce=%b tog=%b busy=%b",
               name, got.rstb, got.ce, got.tog, got.busy, exp.rstb, exp.ce, exp.tog, exp.busy);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  initial begin
    vec_t e;
    vec_t g;
    forever begin
      @(negedge mclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {rstb, ce_out, clk_tog, busy};
        check_vec($sformatf("cyc%0d", cyc), g, e);
      end
    end
  end

  task automatic step();
    @(posedge mclk);
    model_edge();
    #1;
  endtask

  task automatic do_ld(input int ch, input int v);
    div_ld = 1'b1;
    div_ch = 2'(ch);
    div_val = DW'(v);
    step();
    div_ld = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    #2;
    check_vec("reset_state", {rstb, ce_out, clk_tog, busy}, '0);
    repeat (3) step();
    RESET = 1'b0;
    repeat (9) step();

    pll_lock = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!rstb && n < 100);
    check_int("rstb_rise_cycles", n, RST_DLY + 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!ce_out[0] && n < 100);
    check_int("first_ce0_cycles", n, DIV_RST);

    do_ld(1, 3);
    repeat (10) step();
    do_ld(1, 5);
    repeat (20) step();

    do_ld(0, 4);
    do_ld(2, 6);
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    repeat (30) step();

    div_ld = 1'b1; div_ch = 2'd1; div_val = DW'(7); sync_req = 1'b1;
    step();
    div_ld = 1'b0; sync_req = 1'b0;
    repeat (16) step();

    do_ld(3, 0);
    repeat (10) step();

    pll_lock = 1'b0;
    step();
    check_vec("lock_drop", {rstb, ce_out, 1'b0 ? clk_tog : clk_tog, 1'b0} & {1'b1, {NCH{1'b1}}, {NCH{1'b0}}, 1'b0}, '0);
    do_ld(2, 3);
    pll_lock = 1'b1;
    step();
    do_ld(2, 7);
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    repeat (30) step();

    for (int k = 0; k < 2000; k++) begin
      div_ld = ($urandom_range(0, 7) == 0);
      div_ch = 2'($urandom_range(0, 3));
      div_val = DW'($urandom_range(0, 9));
      sync_req = ($urandom_range(0, 49) == 0);
      if (pll_lock) pll_lock = ($urandom_range(0, 399) != 0);
      else pll_lock = ($urandom_range(0, 3) == 0);
      step();
    end
    div_ld = 1'b0;
    sync_req = 1'b0;

    pll_lock = 1'b1;
    do_ld(0, 5);
    repeat (30) step();
    #5;
    RESET = 1'b1;
    #1;
    check_vec("async_reset", {rstb, ce_out, clk_tog, busy}, '0);
    model_reset();
    repeat (2) step();
    RESET = 1'b0;
    repeat (30) step();

    #10;
    check_int("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
